// File: rtl/calc_core.sv
// calc_core: debounced enter button, operand A/B entry FSM and 8-bit signed add/subtract.
module calc_core #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_data,
    input  logic       sw_op,
    input  logic       btn_enter,
    output logic [7:0] result,
    output logic       overflow,
    output logic       result_valid,
    output logic [1:0] state_code
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        CALC  = 2'b10,
        SHOW  = 2'b11
    } state_e;

    // Button synchronizer and debouncer state
    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_c;

    // Switch sample registers, operand latches and FSM state
    logic [DW-1:0] data_q;
    logic          op_s_q;
    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          op_q, op_d;
    logic [DW-1:0] result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;

    // Arithmetic datapath
    logic [DW-1:0] b_eff_c;
    logic [DW-1:0] sum_c;
    logic          ovf_c;

    // Debounce counter: counts while synchronized level disagrees, commits after DEBOUNCE_CYCLES samples
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign strobe_c = deb_q & ~deb_prev_q;

    // Add or subtract (A + ~B + 1) with signed overflow from operand signs
    assign b_eff_c = op_q ? ~b_q : b_q;
    assign sum_c   = a_q + b_eff_c + DW'(op_q);
    assign ovf_c   = op_q ? ((a_q[DW-1] != b_q[DW-1]) && (sum_c[DW-1] != a_q[DW-1]))
                          : ((a_q[DW-1] == b_q[DW-1]) && (sum_c[DW-1] != a_q[DW-1]));

    // Next-state and registered-output logic for the entry/compute/show sequence
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        unique case (state_q)
            GET_A: begin
                result_d = data_q;
                if (strobe_c) begin
                    a_d     = data_q;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                result_d = data_q;
                if (strobe_c) begin
                    b_d     = data_q;
                    op_d    = op_s_q;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d = sum_c;
                ovf_d    = ovf_c;
                valid_d  = 1'b1;
                state_d  = SHOW;
            end
            SHOW: begin
                if (strobe_c) begin
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // All state registers; synchronizer and debounced level reset high so a held button cannot fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            data_q     <= '0;
            op_s_q     <= 1'b0;
            state_q    <= GET_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync1_q    <= btn_enter;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            data_q     <= sw_data;
            op_s_q     <= sw_op;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign result       = result_q;
    assign overflow     = ovf_q;
    assign result_valid = valid_q;
    assign state_code   = state_q;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: reset, echo latency, add/sub results, bounce rejection, mid-run reset.
module tb_calc_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw_data = 8'h00;
    logic       sw_op = 1'b0;
    logic       btn_enter = 1'b0;
    logic [7:0] result;
    logic       overflow;
    logic       result_valid;
    logic [1:0] state_code;

    int n_vec = 0;
    int n_err = 0;
    int changes = 0;
    int calc_cycles = 0;
    logic [1:0] prev_st = 2'b00;

    calc_core #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_data      (sw_data),
        .sw_op        (sw_op),
        .btn_enter    (btn_enter),
        .result       (result),
        .overflow     (overflow),
        .result_valid (result_valid),
        .state_code   (state_code)
    );

    always #5 clk = ~clk;

    // Count state transitions and cycles spent in CALC, sampled mid-cycle
    always @(negedge clk) begin
        if (state_code != prev_st) changes = changes + 1;
        if (state_code == 2'b10) calc_cycles = calc_cycles + 1;
        prev_st = state_code;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn_enter = 1'b1;
        cyc(10);
        btn_enter = 1'b0;
        cyc(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_enter = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
    endtask

    task automatic test_reset();
        logic [11:0] exp_v;
        int c0;
        rst = 1'b1;
        btn_enter = 1'b1;
        sw_data = 8'h00;
        cyc(2);
        @(negedge clk);
        exp_v = 12'h000;
        n_vec++;
        if ({state_code, result_valid, overflow, result} !== exp_v) begin
            n_err++;
            $display("FAIL reset_outputs got %h want %h", {state_code, result_valid, overflow, result}, exp_v);
        end
        cyc(1);
        rst = 1'b0;
        c0 = changes;
        cyc(20);
        @(negedge clk);
        n_vec++;
        if (state_code !== 2'b00 || changes != c0) begin
            n_err++;
            $display("FAIL held_button_no_strobe state %b changes %0d want 00 and 0", state_code, changes - c0);
        end
        cyc(1);
        btn_enter = 1'b0;
        cyc(10);
        press();
        @(negedge clk);
        n_vec++;
        if (state_code !== 2'b01) begin
            n_err++;
            $display("FAIL press_after_release state %b want 01", state_code);
        end
        cyc(1);
    endtask

    task automatic test_echo();
        sw_data = 8'h00;
        do_reset();
        sw_data = 8'hA5;
        @(negedge clk);
        cyc(1);
        @(negedge clk);
        n_vec++;
        if (result !== 8'h00) begin
            n_err++;
            $display("FAIL echo_1cycle result %h want 00", result);
        end
        cyc(1);
        @(negedge clk);
        n_vec++;
        if (result !== 8'hA5) begin
            n_err++;
            $display("FAIL echo_2cycle result %h want a5", result);
        end
        cyc(1);
    endtask

    task automatic test_calc(input logic [7:0] a, input logic [7:0] b, input logic op,
                             input logic [7:0] er, input logic eo);
        int cc;
        sw_data = a;
        sw_op = 1'b0;
        press();
        @(negedge clk);
        n_vec++;
        if ({state_code, result} !== {2'b01, a}) begin
            n_err++;
            $display("FAIL calc_get_b a=%h state/result %b/%h want 01/%h", a, state_code, result, a);
        end
        cyc(1);
        sw_data = b;
        sw_op = op;
        cc = calc_cycles;
        press();
        @(negedge clk);
        n_vec++;
        if ({state_code, result_valid, overflow, result} !== {2'b11, 1'b1, eo, er} || calc_cycles - cc != 1) begin
            n_err++;
            $display("FAIL calc_show a=%h b=%h op=%b got st%b v%b ov%b r%h calc%0d want st11 v1 ov%b r%h calc1",
                     a, b, op, state_code, result_valid, overflow, result, calc_cycles - cc, eo, er);
        end
        cyc(1);
        sw_data = ~b;
        sw_op = ~op;
        cyc(5);
        @(negedge clk);
        n_vec++;
        if ({result, overflow} !== {er, eo}) begin
            n_err++;
            $display("FAIL calc_hold a=%h b=%h got r%h ov%b want r%h ov%b", a, b, result, overflow, er, eo);
        end
        cyc(1);
        press();
        @(negedge clk);
        n_vec++;
        if ({state_code, result_valid, overflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL calc_return a=%h b=%h got st%b v%b ov%b want st00 v0 ov0",
                     a, b, state_code, result_valid, overflow);
        end
        cyc(1);
    endtask

    task automatic test_bounce();
        int c0;
        sw_data = 8'h11;
        do_reset();
        c0 = changes;
        btn_enter = 1'b1; cyc(3);
        btn_enter = 1'b0; cyc(3);
        btn_enter = 1'b1; cyc(3);
        btn_enter = 1'b0; cyc(3);
        btn_enter = 1'b1; cyc(10);
        btn_enter = 1'b0; cyc(10);
        @(negedge clk);
        n_vec++;
        if (state_code !== 2'b01 || changes - c0 != 1) begin
            n_err++;
            $display("FAIL bounce state %b advances %0d want 01 and 1", state_code, changes - c0);
        end
        cyc(1);
    endtask

    task automatic test_reset_mid();
        sw_data = 8'h40;
        do_reset();
        press();
        sw_data = 8'h22;
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({state_code, result_valid, overflow, result} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_mid got %h want 000", {state_code, result_valid, overflow, result});
        end
        cyc(1);
        rst = 1'b0;
        cyc(10);
        test_calc(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_echo();
        do_reset();
        test_calc(8'h64, 8'h32, 1'b0, 8'h96, 1'b1);
        test_calc(8'h05, 8'h09, 1'b1, 8'hFC, 1'b0);
        test_calc(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
        test_calc(8'h80, 8'h00, 1'b0, 8'h80, 1'b0);
        test_calc(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1);
        test_bounce();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
